// File: rtl/t_countdown8_timer.sv
// Down-counting timer with parallel load, reload register and optional auto-reload.
// Terminal count is Q=0 with En=1 in RUN; Done pulses for one cycle after it.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | stopped; Q holds its value, waits for Start or Ld
//   S_RUN  | counting down on enabled edges; terminal count at Q=0
//   S_DONE | one-shot count finished; Q stays 0 until Start or Ld
module t_countdown8_timer #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Ld,
  input  logic [WIDTH-1:0] Ds,
  input  logic             Start,
  input  logic             Stop,
  input  logic             En,
  input  logic             Reload,
  output logic [WIDTH-1:0] Q,
  output logic             Bout,
  output logic             Done,
  output logic             Busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_reload;
  logic             r_done;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_reload_nxt;
  logic             w_done_nxt;
  logic             w_tc;

  // Terminal count: an enabled RUN cycle that finds the counter already at zero.
  assign w_tc = (r_state == S_RUN) && En && (r_q == '0);

  // Register update; Clr clears everything immediately, independent of the clock.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      r_state  <= S_IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Next-state decode in priority order: Ld, Stop, Start, then counting.
  always_comb begin
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_done_nxt   = 1'b0;
    if (Ld) begin
      w_q_nxt      = Ds;
      w_reload_nxt = Ds;
      w_state_nxt  = S_IDLE;
    end else if (Stop) begin
      w_state_nxt = S_IDLE;
    end else if (Start && (r_state != S_RUN)) begin
      w_state_nxt = S_RUN;
    end else if (w_tc) begin
      w_done_nxt = 1'b1;
      if (Reload) begin
        w_q_nxt = r_reload;
      end else begin
        w_state_nxt = S_DONE;
      end
    end else if ((r_state == S_RUN) && En) begin
      // Only reached with Q non-zero, so the decrement can never wrap.
      w_q_nxt = r_q - WIDTH'(1);
    end
  end

  assign Q    = r_q;
  assign Done = r_done;
  assign Busy = (r_state == S_RUN);
  assign Bout = w_tc;

endmodule

// File: tb/tb_t_countdown8_timer.sv
// Self-checking bench for t_countdown8_timer: directed scenarios plus a
// randomized phase, all compared against a behavioural timer model.
module tb_t_countdown8_timer;

  localparam int WIDTH = 8;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic             Clk = 1'b0;
  logic             Clr = 1'b0;
  logic             Ld = 1'b0;
  logic [WIDTH-1:0] Ds = '0;
  logic             Start = 1'b0;
  logic             Stop = 1'b0;
  logic             En = 1'b0;
  logic             Reload = 1'b0;
  logic [WIDTH-1:0] Q;
  logic             Bout;
  logic             Done;
  logic             Busy;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  int m_state = M_IDLE;
  int m_q     = 0;
  int m_r     = 0;
  int m_done  = 0;

  t_countdown8_timer #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Clr(Clr), .Ld(Ld), .Ds(Ds), .Start(Start), .Stop(Stop),
    .En(En), .Reload(Reload), .Q(Q), .Bout(Bout), .Done(Done), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_state = M_IDLE;
    m_q     = 0;
    m_r     = 0;
    m_done  = 0;
  endfunction

  // One rising edge of the timer, written from the behavioural rules.
  function automatic void model_edge();
    int done_next;
    done_next = 0;
    if (Clr) begin
      model_reset();
      return;
    end
    if (Ld) begin
      m_q = int'(Ds);
      m_r = int'(Ds);
      m_state = M_IDLE;
    end else if (Stop) begin
      m_state = M_IDLE;
    end else if (Start && m_state != M_RUN) begin
      m_state = M_RUN;
    end else if (m_state == M_RUN && En) begin
      if (m_q == 0) begin
        done_next = 1;
        if (Reload) m_q = m_r;
        else m_state = M_DONE;
      end else begin
        m_q = m_q - 1;
      end
    end
    m_done = done_next;
  endfunction

  function automatic int model_bout();
    return (m_state == M_RUN && En && m_q == 0) ? 1 : 0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".Q"},    32'(Q),    32'(m_q));
    chk({tag, ".Busy"}, 32'(Busy), 32'(m_state == M_RUN));
    chk({tag, ".Done"}, 32'(Done), 32'(m_done));
    chk({tag, ".Bout"}, 32'(Bout), 32'(model_bout()));
  endtask

  // Advance one clock edge and compare everything 1 time unit later.
  task automatic tick(input string tag);
    @(posedge Clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  task automatic idle_inputs();
    Ld = 0; Stop = 0; Start = 0; En = 0; Reload = 0; Ds = '0;
  endtask

  task automatic load_and_start(input logic [WIDTH-1:0] val, input logic rl, input logic en);
    Ld = 1; Ds = val; Stop = 0; Start = 0; En = 0; Reload = rl;
    tick("load");
    Ld = 0; Start = 1; En = en;
    tick("start");
    chk("start.q_unchanged", 32'(Q), 32'(val));
    chk("start.busy", 32'(Busy), 32'd1);
    Start = 0;
  endtask

  initial begin
    int done_cnt;
    int busy_low;

    // Reset state
    Clr = 1;
    #2;
    model_reset();
    check_model("reset");
    @(posedge Clk);
    #1;
    check_model("reset_held");
    Clr = 0;
    tick("post_reset");
    chk("post_reset.idle", 32'(Busy), 32'd0);

    // One-shot from 3
    load_and_start(8'd3, 1'b0, 1'b1);
    tick("os1"); chk("os.q2", 32'(Q), 32'd2);
    tick("os2"); chk("os.q1", 32'(Q), 32'd1);
    tick("os3"); chk("os.q0", 32'(Q), 32'd0);
    chk("os.bout_at_zero", 32'(Bout), 32'd1);
    tick("os4");
    chk("os.done", 32'(Done), 32'd1);
    chk("os.busy_done_state", 32'(Busy), 32'd0);
    chk("os.q_hold0", 32'(Q), 32'd0);
    tick("os5");
    chk("os.done_one_cycle", 32'(Done), 32'd0);
    chk("os.bout_low_done", 32'(Bout), 32'd0);

    // Auto-reload from 2: period of 3 enabled edges
    load_and_start(8'd2, 1'b1, 1'b1);
    done_cnt = 0;
    busy_low = 0;
    for (int i = 0; i < 9; i++) begin
      tick("reload");
      if (Done) done_cnt++;
      if (!Busy) busy_low++;
    end
    chk("reload.done_count", 32'(done_cnt), 32'd3);
    chk("reload.busy_low_cycles", 32'(busy_low), 32'd0);

    // En low holds Q in RUN
    load_and_start(8'd5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick("hold");
      chk("hold.q5", 32'(Q), 32'd5);
    end
    En = 1;
    tick("resume");
    chk("resume.q4", 32'(Q), 32'd4);

    // Ld, Stop and Start together while running: load wins, go idle
    Ld = 1; Stop = 1; Start = 1; Ds = 8'h80;
    tick("prio");
    chk("prio.q80", 32'(Q), 32'h80);
    chk("prio.busy", 32'(Busy), 32'd0);
    idle_inputs();
    tick("prio_idle");

    // Asynchronous Clr mid-count at Q=0x10
    load_and_start(8'h20, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) tick("pre_clr");
    chk("pre_clr.q10", 32'(Q), 32'h10);
    #3;
    Clr = 1;
    #1;
    chk("clr.q_immediate", 32'(Q), 32'd0);
    chk("clr.busy", 32'(Busy), 32'd0);
    chk("clr.bout", 32'(Bout), 32'd0);
    model_reset();
    #1;
    Clr = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick("after_clr");
      if (Done) done_cnt++;
    end
    chk("after_clr.no_done", 32'(done_cnt), 32'd0);
    chk("after_clr.idle", 32'(Busy), 32'd0);

    // Reload from zero: terminal count on every enabled edge
    load_and_start(8'd0, 1'b1, 1'b1);
    chk("zero.bout_start", 32'(Bout), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick("zero");
      chk("zero.q", 32'(Q), 32'd0);
      chk("zero.bout", 32'(Bout), 32'd1);
      chk("zero.done", 32'(Done), 32'd1);
    end

    // Start from DONE with Q=0 gives an immediate terminal count
    Reload = 0;
    tick("to_done");
    chk("to_done.busy", 32'(Busy), 32'd0);
    Start = 1;
    tick("restart");
    Start = 0;
    tick("restart_tc");
    chk("restart_tc.done", 32'(Done), 32'd1);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      Ld     = ($urandom_range(0, 29) == 0);
      Stop   = ($urandom_range(0, 39) == 0);
      Start  = ($urandom_range(0, 7) == 0);
      En     = ($urandom_range(0, 3) != 0);
      Reload = $urandom_range(0, 1);
      Ds     = WIDTH'($urandom_range(0, 12));
      Clr    = ($urandom_range(0, 99) == 0);
      tick("rand");
    end
    Clr = 0;
    idle_inputs();
    tick("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
